register_file_wb: RTL
=====================

// Module: register_file_wb
// PURPOSE
//   Architectural integer register file for the 5-stage RISC-V core. It is the
//   consumer end of the writeback interface. It accepts one write per cycle
//   (RegWriteW/RD_W/ResultW) and serves two combinational read ports to decode.
//   It also keeps a per-register pending-write scoreboard (issue increments,
//   writeback decrements) so the hazard unit can stall decode on RAW hazards.
// PARAMETERS
//   XLEN   32  data width of each register
//   NREG   32  number of registers; x0 is hardwired to zero
//   CNTW   2   width of each pending-write counter; max in-flight = 2**CNTW-1
// PORTS
//   clk             in   1     clock; all state updates on posedge
//   rst             in   1     asynchronous, active-low reset
//   RegWriteW       in   1     writeback write enable
//   RD_W            in   5     writeback destination register
//   ResultW         in   XLEN  writeback data
//   A1, A2          in   5     decode read addresses (rs1, rs2)
//   RD1, RD2        out  XLEN  read data for A1/A2 (combinational)
//   IssueRegWriteD  in   1     decode issues an instruction that will write IssueRdD
//   IssueRdD        in   5     destination register of the issuing instruction
//   Busy1, Busy2    out  1     A1/A2 has a nonzero pending-write count
//   IssueStall      out  1     IssueRdD counter is saturated; the issue is refused
// BEHAVIOUR
//   - Reset (rst==0, async): all registers -> 0; all counters -> 0.
//     Combinationally, RD1/RD2 = 0, Busy1/Busy2 = 0 and IssueStall = 0.
//     Reset mid-operation drops all in-flight scoreboard state.
//   - Write: on posedge with RegWriteW && RD_W!=0, reg[RD_W] <= ResultW.
//     Writes to x0 are ignored.
//   - Read: RDn = (An==0) ? 0 : reg[An]. No registered latency.
//   - Scoreboard, per register r!=0:
//       inc = IssueRegWriteD && IssueRdD==r && !IssueStall
//       dec = RegWriteW && RD_W==r
//   - Counter update on posedge:
//       inc && dec -> cnt unchanged
//       inc only   -> cnt+1
//       dec only   -> cnt-1
//       dec with cnt==0 -> cnt stays 0 (underflow clamps). Sim builds flag it with $error.
//   - IssueStall = IssueRegWriteD && IssueRdD!=0 && cnt[IssueRdD]==2**CNTW-1 && !dec[IssueRdD].
//     When saturated and decremented in the same cycle, the issue is accepted and cnt is unchanged.
//   - x0: counter is permanently 0; Busy is never set for A==0; IssueRdD==0 is a no-op.
//   - Busyn = cnt[An]!=0 (without bypass, see CONFIGURATION).
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - Same-cycle write-through: if RegWriteW && RD_W==An && An!=0, then RDn = ResultW.
//     - Busyn = cnt[An]!=0 && !(cnt[An]==1 && dec[An]); a retiring final writer does not stall.
//   REGFILE_BYPASS_EN undefined:
//     - RDn returns the pre-write value; the write is visible the next cycle.
//     - Busyn = cnt[An]!=0 unconditionally.
//     - Decode stalls one extra cycle on a WB->D dependency.
// STRUCTURE
//   - Package riscv_pkg:
//       XLEN
//       REG_ADDR_W=5
//       REG_X0=5'd0
//       typedef logic [XLEN-1:0] word_t
//       typedef logic [REG_ADDR_W-1:0] regaddr_t
//   - Sub-module pending_counter: one CNTW-bit up/down counter.
//       Inputs: clk, rst, inc, dec.
//       Outputs: cnt, full.
//       Implements the clamp and simultaneous-update rules.
//     register_file_wb generates NREG-1 instances of it, for r=1..NREG-1.
//   - register_file_wb itself holds the data array, the read muxes and the bypass logic.
// TESTING
//   1. Reset then read x1..x31 -> all RD1/RD2=0, Busy1/Busy2=0; write x0=0xDEADBEEF -> A1=0 reads 0.
//   2. RegWriteW=1, RD_W=5, ResultW=0x12345678, A1=5 same cycle:
//      bypass -> RD1=0x12345678; no bypass -> old value, 0x12345678 next cycle.
//   3. Issue rd=7 three times (CNTW=2) -> Busy1(A1=7)=1; 4th issue -> IssueStall=1, cnt stays 3;
//      three writebacks to x7 -> Busy1 drops after the third (one cycle earlier with bypass).
//   4. Same cycle: IssueRdD=9 issue and RD_W=9 writeback at cnt=1 -> cnt stays 1, Busy(9)=1;
//      at cnt=3 -> IssueStall=0, cnt stays 3.
//   5. cnt[3]=2 and reg[3]=0xA5, then assert rst mid-cycle -> immediately reg[3]=0, Busy=0;
//      writeback to x3 afterwards -> cnt stays 0, sim $error raised.
//   6. Random interleaved issue/writeback against a reference model for 10k cycles
//      -> RD1/RD2/Busy1/Busy2/IssueStall match every cycle.

Source files
------------

// File: rtl/register_file_wb_pkg.sv
// riscv_pkg: shared widths and types for the register file and its writeback/decode interface
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [REG_ADDR_W-1:0] regaddr_t;
  localparam regaddr_t REG_X0 = 5'd0;
endpackage

// File: rtl/register_file_wb_if.sv
// register_file_wb_if: writeback, decode read and issue-scoreboard signals of the register file
interface register_file_wb_if;
  import riscv_pkg::*;
  logic     RegWriteW;
  regaddr_t RD_W;
  word_t    ResultW;
  regaddr_t A1;
  regaddr_t A2;
  word_t    RD1;
  word_t    RD2;
  logic     IssueRegWriteD;
  regaddr_t IssueRdD;
  logic     Busy1;
  logic     Busy2;
  logic     IssueStall;
  modport master (
    output RegWriteW, RD_W, ResultW, A1, A2, IssueRegWriteD, IssueRdD,
    input  RD1, RD2, Busy1, Busy2, IssueStall
  );
  modport slave (
    input  RegWriteW, RD_W, ResultW, A1, A2, IssueRegWriteD, IssueRdD,
    output RD1, RD2, Busy1, Busy2, IssueStall
  );
endinterface

// File: rtl/register_file_wb_pending_counter.sv
// pending_counter: per-register in-flight writer count; simultaneous inc/dec holds, underflow clamps at zero
module pending_counter #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            full
);
  logic [CNTW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc == dec) ? cnt_q : inc ? cnt_q + 1'b1 : (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt  = cnt_q;
  assign full = &cnt_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (rst && dec && !inc && cnt_q == '0) $error("pending_counter: writeback with no pending writer");
`endif
endmodule

// File: rtl/register_file_wb.sv
// register_file_wb: integer register file with two combinational read ports and a RAW pending-write scoreboard
// Optional same-cycle WB->D write-through and early Busy release: define REGFILE_BYPASS_EN
module register_file_wb
  import riscv_pkg::*;
#(
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input logic               clk,
  input logic               rst,
  register_file_wb_if.slave bus
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  word_t           regs_q [NREG];
  logic [CNTW-1:0] cnt [NREG];
  logic [NREG-1:0] full, dec;
  logic            hit1, hit2;
  assign cnt[0]  = '0;
  assign full[0] = 1'b0;
  assign dec[0]  = 1'b0;
  // A saturated destination may still issue when its oldest writer retires this cycle
  assign bus.IssueStall = bus.IssueRegWriteD && bus.IssueRdD != REG_X0 && full[bus.IssueRdD] && !dec[bus.IssueRdD];
  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign dec[r] = bus.RegWriteW && bus.RD_W == regaddr_t'(r);
    pending_counter #(.CNTW(CNTW)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (bus.IssueRegWriteD && bus.IssueRdD == regaddr_t'(r) && !bus.IssueStall),
      .dec  (dec[r]),
      .cnt  (cnt[r]),
      .full (full[r])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (bus.RegWriteW && bus.RD_W != REG_X0) regs_q[bus.RD_W] <= bus.ResultW;
  assign hit1 = BYP && rst && bus.RegWriteW && bus.RD_W == bus.A1;
  assign hit2 = BYP && rst && bus.RegWriteW && bus.RD_W == bus.A2;
  assign bus.RD1 = (bus.A1 == REG_X0) ? '0 : hit1 ? bus.ResultW : regs_q[bus.A1];
  assign bus.RD2 = (bus.A2 == REG_X0) ? '0 : hit2 ? bus.ResultW : regs_q[bus.A2];
  assign bus.Busy1 = cnt[bus.A1] != '0 && !(BYP && cnt[bus.A1] == CNTW'(1) && dec[bus.A1]);
  assign bus.Busy2 = cnt[bus.A2] != '0 && !(BYP && cnt[bus.A2] == CNTW'(1) && dec[bus.A2]);
endmodule
